// File: rtl/ula_arbitro.sv
`default_nettype none
// ula_arbitro: round-robin two-client arbiter/sequencer for the shared ULA_8b.
// Grants one client, drives registered ALU inputs, captures the result one cycle later.
module ula_arbitro #(
  parameter int N  = 8,
  parameter int NF = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [N-1:0]  A0,
  input  logic [N-1:0]  B0,
  input  logic [N-1:0]  A1,
  input  logic [N-1:0]  B1,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  output logic          ack0,
  output logic          ack1,
  output logic          done0,
  output logic          done1,
  output logic [N-1:0]  res0,
  output logic [N-1:0]  res1,
  output logic [NF-1:0] flg0,
  output logic [NF-1:0] flg1,
  output logic [N-1:0]  ula_A,
  output logic [N-1:0]  ula_B,
  output logic          ula_x,
  output logic          ula_y,
  input  logic [N-1:0]  ula_saida,
  input  logic [NF-1:0] ula_flag
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state_q;
  logic            ultimo_q;
  logic            sel_q;
  logic [1:0]      ack_q;
  logic [1:0]      done_q;
  logic [N-1:0]    res0_q;
  logic [N-1:0]    res1_q;
  logic [NF-1:0]   flg0_q;
  logic [NF-1:0]   flg1_q;
  logic [N-1:0]    ula_A_q;
  logic [N-1:0]    ula_B_q;
  logic [1:0]      ula_op_q;

  logic            grant_any_d;
  logic            grant_idx_d;

  // On a tie the client that was not served last wins.
  always_comb begin
    grant_any_d = req0 | req1;
    grant_idx_d = (req0 && req1) ? ~ultimo_q : req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ultimo_q <= 1'b1;
      sel_q    <= 1'b0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      res0_q   <= '0;
      res1_q   <= '0;
      flg0_q   <= '0;
      flg1_q   <= '0;
      ula_A_q  <= '0;
      ula_B_q  <= '0;
      ula_op_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          ack_q  <= 2'b00;
          if (grant_any_d) begin
            ula_A_q  <= grant_idx_d ? A1 : A0;
            ula_B_q  <= grant_idx_d ? B1 : B0;
            ula_op_q <= grant_idx_d ? op1 : op0;
            ack_q    <= grant_idx_d ? 2'b10 : 2'b01;
            ultimo_q <= grant_idx_d;
            sel_q    <= grant_idx_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (sel_q) begin
            res1_q <= ula_saida;
            flg1_q <= ula_flag;
          end else begin
            res0_q <= ula_saida;
            flg0_q <= ula_flag;
          end
          done_q  <= sel_q ? 2'b10 : 2'b01;
          ack_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0  = ack_q[0];
  assign ack1  = ack_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign res0  = res0_q;
  assign res1  = res1_q;
  assign flg0  = flg0_q;
  assign flg1  = flg1_q;
  assign ula_A = ula_A_q;
  assign ula_B = ula_B_q;
  assign ula_x = ula_op_q[1];
  assign ula_y = ula_op_q[0];

endmodule
`default_nettype wire

// File: doc/ula_arbitro.md
# ula_arbitro

Two-port arbiter and sequencer for the shared 8-bit ALU (`ULA_8b`). It accepts operation requests from two clients, each with its own operands and op select. It grants the ALU to one client at a time using round-robin priority and drives the ALU inputs from registers. It then captures the combinational result and flags and returns them to the granted client with a done pulse. It sits between the control units that need arithmetic/logic (e.g. multiplier and divider sequencers) and the single `ULA_8b` instance.

## Interface
Parameters:
- `N`, 8: operand/result width; must match the ALU width.
- `NF`, 4: flag width; must match the ALU flag width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  operation request from client 0 / 1.
- `A0`, `B0`, `A1`, `B1`  in  N  operands of each client; sampled only on grant.
- `op0`, `op1`  in  2  op select per client, as {x,y}:
  - 00 = add
  - 01 = AND
  - 10 = OR
  - 11 = NOT A
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted, operands latched.
- `done0`, `done1`  out  1  one-cycle pulse: `res`/`flg` of that client updated.
- `res0`, `res1`  out  N  last result returned to that client; held until its next done.
- `flg0`, `flg1`  out  NF  ALU flag captured with that result; held likewise.
- `ula_A`, `ula_B`  out  N  registered operands driven to the ALU.
- `ula_x`, `ula_y`  out  1  registered op select driven to the ALU.
- `ula_saida`  in  N  ALU result (combinational from `ula_*`).
- `ula_flag`  in  NF  ALU flags (combinational from `ula_*`).

## Operation
- FSM states:
  - IDLE: sample `req0`/`req1`.
  - EXEC: ALU inputs stable, result being captured.
- IDLE transitions:
  - No request: stay in IDLE; ALU input registers hold their last values.
  - Exactly one request: grant it.
  - Both requests: grant the client not equal to `ultimo` (last-granted pointer).
- On grant (edge leaving IDLE):
  - `ula_A`/`ula_B`/`{ula_x,ula_y}` <= granted client's A/B/op.
  - `ack` of that client <= 1.
  - `ultimo` <= granted index; `sel` <= granted index.
  - State <= EXEC.
- On EXEC edge:
  - `res[sel]` <= `ula_saida`; `flg[sel]` <= `ula_flag`.
  - `done[sel]` <= 1; acks <= 0; state <= IDLE.
- The other client's `res`/`flg` are never touched.
- Flags are passed through as the ALU produces them. The arbiter does not interpret flag bits.
- For NOT (op 11), B is still latched to `ula_B` and ignored by the ALU.
- Client rule:
  - Hold req/A/B/op stable until ack is seen high.
  - A req still high at the next IDLE sample counts as a new request with the then-current operands.
- At most one ack and at most one done are high in any cycle.

## Timing
- Reset (async, immediate on `rst_n`=0):
  - State = IDLE, `ultimo` = 1 (client 0 wins the first tie).
  - All ack/done = 0.
  - `res*`, `flg*`, `ula_A`, `ula_B`, `ula_x`, `ula_y` = 0.
  - A reset asserted in EXEC discards the operation; no done follows.
  - Requests held across reset release are sampled at the first edge with `rst_n`=1.
- Latency, with request sampled at edge e0:
  - ack high during e0→e1.
  - done high and `res` valid during e1→e2; `res` holds afterwards.
- Throughput: one operation per 2 cycles. Done of op k coincides with IDLE sampling for op k+1, so back-to-back requests see ack every 2 cycles.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1…; neither client waits more than one operation.

## Test plan
- Reset: drive `rst_n`=0 with `req0`=1 mid-EXEC -> all outputs 0 immediately, no done0. After release, first grant is at the first sampled edge.
- Single client: `req0`, A0=0x01, B0=0x03, op0=00 -> `ack0` pulse next cycle, then `done0` with `res0`=0x04. `ula_*` equal 0x01/0x03/0/0 during EXEC; `res1`/`done1` unchanged.
- Tie and round-robin: from reset, `req0` (0x7F+0x7F, op 00) and `req1` (0x01 OR 0x02, op 10) both high -> client 0 served first with `res0`=0xFE and `flg0`=`ula_flag` captured. Then client 1 with `res1`=0x03. A new simultaneous pair -> client 0 first again.
- Back-to-back: `req1` held high for 4 operations, `req0` idle -> `ack1` every 2 cycles. Raising `req0` mid-stream -> client 0 granted at the next IDLE, then client 1 resumes.
- NOT op: `req1`, A1=0x01, B1=0xAA, op1=11 -> `res1`=0xFE two cycles after grant edge.
- Hold check: after done0, change A0 without `req0` -> `res0`, `flg0`, `ula_A` all unchanged.
